xc_fifo_wr_packer: RTL and testbench
====================================

Name: xc_fifo_wr_packer

Overview:
- Upstream feeder for the sync FIFO / FWFT wrapper.
- Accepts a narrow valid/ready byte-lane stream and packs RATIO beats into one FIFO word.
- Drives the FIFO write side (wr, data) and honours the FIFO full flag.
- A beat flagged last flushes a partial word, with unused lanes zero-filled.

Parameters:
- IN_WIDTH, 8, width of one input beat.
- RATIO, 4, beats per FIFO word; power of two, >= 2.
- LOG2_RATIO, 2, log2(RATIO).
- Derived localparam: OUT_WIDTH = IN_WIDTH*RATIO. It must equal the downstream FIFO WIDTH.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- clr_i  in  1  synchronous clear; same effect as rst_i, lower priority.
- s_valid_i  in  1  input beat valid.
- s_data_i  in  IN_WIDTH  input beat data.
- s_last_i  in  1  beat closes the current word (flush).
- s_ready_o  out  1  beat accepted when s_valid_i && s_ready_o.
- fifo_wr_o  out  1  FIFO write strobe (to FIFO wr_i).
- fifo_data_o  out  OUT_WIDTH  FIFO write data (to FIFO data_i).
- fifo_full_i  in  1  FIFO full (from FIFO full_o).
- busy_o  out  1  partial word or pending word held.

Behaviour:
- Storage:
  - acc: OUT_WIDTH accumulator.
  - cnt: LOG2_RATIO-bit lane index.
  - hold_data: OUT_WIDTH register, with hold_valid flag.
- Reset (rst_i=1 at a clock edge):
  - acc=0, cnt=0, hold_data=0, hold_valid=0.
  - Resulting outputs: s_ready_o=1, fifo_wr_o=0, fifo_data_o=0, busy_o=0.
- clr_i=1, rst_i=0: identical effect to reset. Any in-flight partial or held word is discarded and never written.
- Combinational outputs:
  - fifo_wr_o = hold_valid && !fifo_full_i.
  - fifo_data_o = hold_data.
  - s_ready_o = !(hold_valid && fifo_full_i).
  - busy_o = hold_valid || (cnt != 0).
- Accepted beat, lane placement:
  - Lane placement is little-endian: beat cnt goes to acc[cnt*IN_WIDTH +: IN_WIDTH].
  - Lane 0 is the LSBs.
- Word completion: an accepted beat completes the word if cnt==RATIO-1 or s_last_i=1. On completion:
  - hold_data <= acc with the current beat merged in.
  - Lanes above the current beat are forced to 0.
  - hold_valid <= 1; acc <= 0; cnt <= 0.
- Non-completing accepted beat: cnt <= cnt+1; hold unchanged.
- Drain: when fifo_wr_o=1, hold_valid <= 0 at the edge.
  - If a completion happens on that same edge, the new word loads and hold_valid stays 1 (back-to-back words, no bubble).
- Latency:
  - The word completed by a beat accepted in cycle k shows fifo_wr_o=1 in cycle k+1 if fifo_full_i=0.
  - Sustained throughput: 1 beat/cycle, 1 word per RATIO cycles.
- Full handling:
  - While hold_valid && fifo_full_i, s_ready_o=0.
  - No beats are accepted, including non-completing ones.
  - acc/cnt are frozen and hold_data is stable.
  - When fifo_full_i falls: in that same cycle fifo_wr_o=1 and s_ready_o=1.
- fifo_wr_o is never asserted while fifo_full_i=1. The FIFO never sees a write-when-full.
- s_last_i with s_valid_i=0 is ignored. s_last_i on lane RATIO-1 behaves as a normal full word.
- Input stability: s_data_i/s_last_i may change whenever s_valid_i=0. While s_valid_i=1 && s_ready_o=0, the source holds them stable.
- Reset/clear mid-operation: takes effect at the edge regardless of valid/full; beats presented that cycle are dropped.

Optional Feature:
- Macro: XC_PACK_TAG_EN.
- When defined:
  - Adds output port fifo_tag_o, width 1+LOG2_RATIO, registered alongside hold_data.
  - fifo_tag_o = {last_flag, nlanes_minus_1}.
  - last_flag is s_last_i of the completing beat.
  - nlanes_minus_1 is the lane index of the completing beat.
  - fifo_tag_o resets to 0.
  - The integrator concatenates fifo_tag_o onto the data path, so the FIFO WIDTH is OUT_WIDTH+1+LOG2_RATIO.
- When undefined: the port is absent and there is no tag storage. Behaviour is otherwise identical.

Test Plan (IN_WIDTH=8, RATIO=4):
1. Beats 0x11,0x22,0x33,0x44 on consecutive cycles, fifo_full_i=0 -> fifo_wr_o=1 for exactly one cycle, the cycle after the 4th beat, with fifo_data_o=0x44332211; s_ready_o stays 1.
2. Beats 0xAA, then 0xBB with s_last_i=1 -> one write of 0x0000BBAA. With XC_PACK_TAG_EN: fifo_tag_o=3'b101.
3. fifo_full_i=1, stream 8 beats 0x01..0x08:
   - 4 beats are accepted, then s_ready_o=0 and fifo_wr_o=0.
   - Drop full -> same cycle fifo_wr_o=1 with 0x04030201 and s_ready_o=1.
   - The remaining beats produce 0x08070605.
4. Beats 0x01,0x02, then clr_i=1 for one cycle, then 0x10,0x20,0x30,0x40 -> single write 0x40302010; no write contains 0x01/0x02.
5. Word held with fifo_full_i=1, rst_i pulsed -> next cycle fifo_wr_o=0, busy_o=0, fifo_data_o=0, s_ready_o=1; no write after releasing full.
6. 12 beats back-to-back with fifo_full_i=0 -> three writes spaced 4 cycles apart, and no s_ready_o deassertion.

Source files
------------

// File: rtl/xc_fifo_wr_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : xc_fifo_wr_packer_if
// Brief    : Beat-stream and FIFO write-side bundle for xc_fifo_wr_packer.
//            The fifo_tag_o lane is present only when XC_PACK_TAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface xc_fifo_wr_packer_if #(
  parameter int IN_WIDTH   = 8,
  parameter int RATIO      = 4,
  parameter int LOG2_RATIO = 2
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;

  logic                 s_valid_i;
  logic [IN_WIDTH-1:0]  s_data_i;
  logic                 s_last_i;
  logic                 s_ready_o;
  logic                 fifo_wr_o;
  logic [OUT_WIDTH-1:0] fifo_data_o;
  logic                 fifo_full_i;
  logic                 busy_o;
`ifdef XC_PACK_TAG_EN
  logic [LOG2_RATIO:0]  fifo_tag_o;

  modport master (
    input  s_valid_i, s_data_i, s_last_i, fifo_full_i,
    output s_ready_o, fifo_wr_o, fifo_data_o, busy_o, fifo_tag_o
  );
  modport slave (
    output s_valid_i, s_data_i, s_last_i, fifo_full_i,
    input  s_ready_o, fifo_wr_o, fifo_data_o, busy_o, fifo_tag_o
  );
`else
  modport master (
    input  s_valid_i, s_data_i, s_last_i, fifo_full_i,
    output s_ready_o, fifo_wr_o, fifo_data_o, busy_o
  );
  modport slave (
    output s_valid_i, s_data_i, s_last_i, fifo_full_i,
    input  s_ready_o, fifo_wr_o, fifo_data_o, busy_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/xc_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module   : xc_fifo_wr_packer
// Brief    : Packs RATIO narrow beats into one little-endian FIFO word and
//            writes it through a single-entry hold stage that honours full.
//            Optional macro XC_PACK_TAG_EN adds fifo_tag_o = {last, nlanes-1}.
// Revision : 1.0 - initial release
// ============================================================================
module xc_fifo_wr_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int RATIO      = 4,
  parameter int LOG2_RATIO = 2
) (
  input wire clk_i,
  input wire rst_i,
  input wire clr_i,
  xc_fifo_wr_packer_if.master bus
);
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam logic [LOG2_RATIO-1:0] C_LAST_LANE = LOG2_RATIO'(RATIO - 1);

  generate
    if ((RATIO < 2) || (RATIO != (1 << LOG2_RATIO))) begin : g_bad_ratio
      $error("xc_fifo_wr_packer: RATIO must be a power of two >= 2 equal to 2**LOG2_RATIO");
    end
  endgenerate

  logic [OUT_WIDTH-1:0]  r_acc;
  logic [LOG2_RATIO-1:0] r_cnt;
  logic [OUT_WIDTH-1:0]  r_hold_data;
  logic                  r_hold_valid;
`ifdef XC_PACK_TAG_EN
  logic [LOG2_RATIO:0]   r_tag;
`endif

  logic [OUT_WIDTH-1:0]  w_merged;
  logic                  w_wr;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_complete;

  assign w_wr       = r_hold_valid && !bus.fifo_full_i;
  assign w_ready    = !(r_hold_valid && bus.fifo_full_i);
  assign w_accept   = bus.s_valid_i && w_ready;
  assign w_complete = w_accept && ((r_cnt == C_LAST_LANE) || bus.s_last_i);

  // Lanes below the index keep accumulated data, the indexed lane takes the
  // incoming beat, and lanes above are zero so a flushed word is zero-filled.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      localparam logic [LOG2_RATIO-1:0] C_IDX = LOG2_RATIO'(gi);
      assign w_merged[gi*IN_WIDTH +: IN_WIDTH] =
          (C_IDX == r_cnt) ? bus.s_data_i :
          (C_IDX <  r_cnt) ? r_acc[gi*IN_WIDTH +: IN_WIDTH] :
                             '0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
`ifdef XC_PACK_TAG_EN
      r_tag        <= '0;
`endif
    end else begin
      if (w_accept) begin
        if (w_complete) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_merged;
          r_cnt <= r_cnt + LOG2_RATIO'(1);
        end
      end
      // A completion on the draining edge reloads the hold stage directly.
      if (w_complete) begin
        r_hold_data  <= w_merged;
        r_hold_valid <= 1'b1;
`ifdef XC_PACK_TAG_EN
        r_tag        <= {bus.s_last_i, r_cnt};
`endif
      end else if (w_wr) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ready_o   = w_ready;
  assign bus.fifo_wr_o   = w_wr;
  assign bus.fifo_data_o = r_hold_data;
  assign bus.busy_o      = r_hold_valid || (r_cnt != '0);
`ifdef XC_PACK_TAG_EN
  assign bus.fifo_tag_o  = r_tag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xc_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xc_fifo_wr_packer
// Brief    : Scoreboard bench for xc_fifo_wr_packer (IN_WIDTH=8, RATIO=4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_xc_fifo_wr_packer;
  localparam int IN_WIDTH   = 8;
  localparam int RATIO      = 4;
  localparam int LOG2_RATIO = 2;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  tag;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  word_t      sb[$];
  logic [7:0] cur[$];

  xc_fifo_wr_packer_if #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO), .LOG2_RATIO(LOG2_RATIO)) bus ();

  xc_fifo_wr_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO), .LOG2_RATIO(LOG2_RATIO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word closes after RATIO beats or on last, lane i = beat i.
  task automatic model_accept(input logic [7:0] d, input logic l);
    word_t w;
    cur.push_back(d);
    if (l || cur.size() == RATIO) begin
      w.data = 32'h0;
      foreach (cur[i]) w.data = w.data | (32'(cur[i]) << (8 * i));
      w.tag = {l, 2'(cur.size() - 1)};
      sb.push_back(w);
      cur.delete();
    end
  endtask

  // Monitor: compares every cycle's outputs against the pending-word model.
  always @(negedge clk) begin
    logic exp_wr;
    word_t w;
    if (mon_en) begin
      exp_wr = (sb.size() > 0) && !bus.fifo_full_i;
      chk("fifo_wr", bus.fifo_wr_o, exp_wr);
      chk("s_ready", bus.s_ready_o, !((sb.size() > 0) && bus.fifo_full_i));
      chk("busy", bus.busy_o, (sb.size() > 0) || (cur.size() > 0));
      if (sb.size() > 0) begin
        chk("fifo_data", bus.fifo_data_o, sb[0].data);
`ifdef XC_PACK_TAG_EN
        chk("fifo_tag", bus.fifo_tag_o, sb[0].tag);
`endif
        if (bus.fifo_wr_o) w = sb.pop_front();
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic full, input logic c, input logic r, output logic acc);
    @(posedge clk);
    #1;
    bus.s_valid_i   = v;
    bus.s_data_i    = d;
    bus.s_last_i    = l;
    bus.fifo_full_i = full;
    clr = c;
    rst = r;
    @(negedge clk);
    #1;
    acc = v && bus.s_ready_o && !c && !r;
    if (c || r) begin
      sb.delete();
      cur.delete();
    end else if (acc) begin
      model_accept(d, l);
    end
  endtask

  task automatic idle(input logic full, input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, full, 1'b0, 1'b0, acc);
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic full);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 40 && !acc; n++) step(1'b1, d, l, full, 1'b0, 1'b0, acc);
    chk("send_accept", acc, 1'b1);
  endtask

  initial begin
    logic acc;
    logic v, l, f, c;
    logic [7:0] d;
    bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.s_last_i = 1'b0; bus.fifo_full_i = 1'b0;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    mon_en = 1'b1;
    idle(1'b0, 1);
    chk("reset_data", bus.fifo_data_o, 32'h0);
    chk("reset_ready", bus.s_ready_o, 1'b1);

    // Full word, then last-flushed partial word.
    send(8'h11, 1'b0, 1'b0); send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0); send(8'h44, 1'b0, 1'b0);
    idle(1'b0, 2);
    send(8'hAA, 1'b0, 1'b0); send(8'hBB, 1'b1, 1'b0);
    idle(1'b0, 2);

    // Full backpressure: fifth beat stalls until full drops.
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      chk("stall_acc", acc, 1'b0);
    end
    for (int i = 5; i <= 8; i++) send(8'(i), 1'b0, 1'b0);
    idle(1'b0, 2);

    // Clear discards a partial word.
    send(8'h01, 1'b0, 1'b0); send(8'h02, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    send(8'h10, 1'b0, 1'b0); send(8'h20, 1'b0, 1'b0);
    send(8'h30, 1'b0, 1'b0); send(8'h40, 1'b0, 1'b0);
    idle(1'b0, 2);

    // Reset while a word is held against full.
    send(8'hAA, 1'b0, 1'b1); send(8'hBB, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    idle(1'b1, 1);
    chk("rst_held_data", bus.fifo_data_o, 32'h0);
    chk("rst_held_busy", bus.busy_o, 1'b0);
    idle(1'b0, 3);

    // Twelve back-to-back beats.
    for (int i = 0; i < 12; i++) send(8'(8'hC0 + i), 1'b0, 1'b0);
    idle(1'b0, 2);

    // Random traffic; a stalled beat is held stable until accepted.
    v = 1'b0; d = '0; l = 1'b0; acc = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(v && !acc)) begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
        l = ($urandom_range(0, 4) == 0);
      end
      f = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 59) == 0);
      step(v, d, l, f, c, 1'b0, acc);
      if (c) acc = 1'b1;
    end

    idle(1'b0, 3);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
